// File: rtl/md_issue_ctrl_pkg.sv
// Shared codes for the mult/div issue sequencer: request kinds, FSM states,
// the unit's MUDI_* op codes and the kind-to-op mapping.
package md_issue_ctrl_pkg;

    localparam logic [3:0] MD_K_NONE  = 4'd0;
    localparam logic [3:0] MD_K_MULT  = 4'd1;
    localparam logic [3:0] MD_K_MULTU = 4'd2;
    localparam logic [3:0] MD_K_DIV   = 4'd3;
    localparam logic [3:0] MD_K_DIVU  = 4'd4;
    localparam logic [3:0] MD_K_MTHI  = 4'd5;
    localparam logic [3:0] MD_K_MTLO  = 4'd6;
    localparam logic [3:0] MD_K_MFHI  = 4'd7;
    localparam logic [3:0] MD_K_MFLO  = 4'd8;

    localparam logic [2:0] MUDI_NONE  = 3'd0;
    localparam logic [2:0] MUDI_MULT  = 3'd1;
    localparam logic [2:0] MUDI_MULTU = 3'd2;
    localparam logic [2:0] MUDI_DIV   = 3'd3;
    localparam logic [2:0] MUDI_DIVU  = 3'd4;
    localparam logic [2:0] MUDI_MTHI  = 3'd5;
    localparam logic [2:0] MUDI_MTLO  = 3'd6;

    // Busy-length counter width; comfortably above the longest divide.
    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        MD_S_IDLE  = 2'd0,
        MD_S_ISSUE = 2'd1,
        MD_S_WAIT  = 2'd2
    } md_state_e;

    // MFHI/MFLO never reach the unit, so they map to MUDI_NONE.
    function automatic logic [2:0] kind_to_op(input logic [3:0] kind);
        case (kind)
            MD_K_MULT:  return MUDI_MULT;
            MD_K_MULTU: return MUDI_MULTU;
            MD_K_DIV:   return MUDI_DIV;
            MD_K_DIVU:  return MUDI_DIVU;
            MD_K_MTHI:  return MUDI_MTHI;
            MD_K_MTLO:  return MUDI_MTLO;
            default:    return MUDI_NONE;
        endcase
    endfunction

endpackage

// File: rtl/md_issue_ctrl_busy_checker.sv
// Measures the unit's busy window after each start and flags a missing busy
// or a window whose length differs from the expected mult/div latency.
module md_busy_checker
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic start_div,
    input  logic in_issue,
    input  logic in_wait,
    input  logic md_busy,
    output logic err_pulse
);

    logic [LEN_W-1:0] exp_len;
    logic [LEN_W-1:0] cnt;

    // NOTE: registers take non-blocking assignments so every flop in the
    // design samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_len <= '0;
            cnt     <= '0;
        end else begin
            if (start)
                exp_len <= start_div ? LEN_W'(DIV_CYCLES) : LEN_W'(MUL_CYCLES);
            // The ISSUE cycle that first sees busy is busy cycle one.
            if (in_issue && md_busy)
                cnt <= LEN_W'(1);
            else if (in_wait && md_busy && cnt != '1)
                cnt <= cnt + LEN_W'(1);
        end
    end

    assign err_pulse = !md_busy && (in_issue || (in_wait && cnt != exp_len));

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/stall sequencer for the shared mult/div unit.
// Define MD_STALL_CNT_EN to build the saturating stall-cycle counter.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [3:0]       req_kind,
    input  logic             flush,
    output logic             req_ready,
    output logic             md_start,
    output logic [2:0]       md_op,
    input  logic             md_busy,
    output logic             rd_sel_hi,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    md_state_e state;
    logic      is_md;
    logic      is_hilo;
    logic      err_pulse;

    assign is_md   = req_kind inside {MD_K_MULT, MD_K_MULTU, MD_K_DIV, MD_K_DIVU};
    assign is_hilo = is_md || (req_kind inside {MD_K_MTHI, MD_K_MTLO, MD_K_MFHI, MD_K_MFLO});

    // NOTE: every output gets a default first so no path leaves one unassigned
    // and infers a latch.
    always_comb begin
        req_ready = 1'b1;
        md_start  = 1'b0;
        md_op     = MUDI_NONE;
        rd_sel_hi = 1'b0;
        // A killed instruction never touches the unit and never stalls.
        if (!rst && req_valid && !flush) begin
            if (state == MD_S_IDLE) begin
                md_op     = kind_to_op(req_kind);
                md_start  = is_md;
                rd_sel_hi = (req_kind == MD_K_MFHI);
            end else if (is_hilo) begin
                req_ready = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_S_IDLE;
            err   <= 1'b0;
        end else begin
            case (state)
                MD_S_IDLE:  if (md_start) state <= MD_S_ISSUE;
                MD_S_ISSUE: state <= md_busy ? MD_S_WAIT : MD_S_IDLE;
                MD_S_WAIT:  if (!md_busy) state <= MD_S_IDLE;
                default:    state <= MD_S_IDLE;
            endcase
            if (err_pulse)
                err <= 1'b1;
        end
    end

    md_busy_checker #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_busy_checker (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .start_div (md_op == MUDI_DIV || md_op == MUDI_DIVU),
        .in_issue  (state == MD_S_ISSUE),
        .in_wait   (state == MD_S_WAIT),
        .md_busy   (md_busy),
        .err_pulse (err_pulse)
    );

`ifdef MD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (req_valid && !flush && !req_ready && stall_q != '1)
            stall_q <= stall_q + CNT_W'(1);
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small behavioural mult/div unit
// that raises busy the cycle after each start for a programmable length.
module tb_md_issue_ctrl;

    localparam logic [3:0] K_NONE = 4'd0, K_MULT = 4'd1, K_MULTU = 4'd2, K_DIV = 4'd3,
                           K_DIVU = 4'd4, K_MTHI = 4'd5, K_MTLO = 4'd6, K_MFHI = 4'd7,
                           K_MFLO = 4'd8;
    localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                           OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
`ifdef MD_STALL_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_kind = K_NONE;
    logic        flush = 1'b0;
    logic        req_ready;
    logic        md_start;
    logic [2:0]  md_op;
    logic        md_busy = 1'b0;
    logic        rd_sel_hi;
    logic        err;
    logic [31:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    // Unit model state
    int  mul_len = 5;
    int  div_len = 10;
    bit  unit_dead = 1'b0;
    int  busy_left = 0;

    always #5 clk = ~clk;

    md_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_kind     (req_kind),
        .flush        (flush),
        .req_ready    (req_ready),
        .md_start     (md_start),
        .md_op        (md_op),
        .md_busy      (md_busy),
        .rd_sel_hi    (rd_sel_hi),
        .err          (err),
        .stall_cycles (stall_cycles)
    );

    // Inputs change just after a falling edge; outputs are read 1 time unit later.
    task automatic apply(input bit v, input logic [3:0] k, input bit f);
        req_valid = v;
        req_kind  = k;
        flush     = f;
        #1;
    endtask

    // Advance one cycle and update the unit model for the new cycle.
    task automatic adv();
        bit          was_start;
        bit          was_rst;
        logic [2:0]  was_op;
        was_start = md_start;
        was_rst   = rst;
        was_op    = md_op;
        @(posedge clk);
        @(negedge clk);
        if (was_rst)
            busy_left = 0;
        else if (was_start && !unit_dead)
            busy_left = (was_op == OP_DIV || was_op == OP_DIVU) ? div_len : mul_len;
        md_busy = (busy_left > 0);
        if (busy_left > 0)
            busy_left--;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, K_NONE, 1'b0);
            adv();
        end
    endtask

    task automatic do_reset();
        mul_len   = 5;
        div_len   = 10;
        unit_dead = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        apply(1'b0, K_NONE, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op, rd_sel_hi, err} !== {1'b1, 1'b0, OP_NONE, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want %b",
                     {req_ready, md_start, md_op, rd_sel_hi, err}, {1'b1, 1'b0, OP_NONE, 1'b0, 1'b0});
        end
        vectors++;
        if (stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_stall_cnt: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_mult_mflo();
        do_reset();
        apply(1'b1, K_MULT, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op} !== {1'b1, 1'b1, OP_MULT}) begin
            miscompares++;
            $display("FAIL mult_issue: got %b want %b", {req_ready, md_start, md_op}, {1'b1, 1'b1, OP_MULT});
        end
        adv();
        for (int c = 1; c <= 6; c++) begin
            apply(1'b1, K_MFLO, 1'b0);
            vectors++;
            if ({req_ready, md_start} !== 2'b00) begin
                miscompares++;
                $display("FAIL mflo_stall_c%0d: got %b want 00", c, {req_ready, md_start});
            end
            adv();
        end
        apply(1'b1, K_MFLO, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op, rd_sel_hi, err} !== {1'b1, 1'b0, OP_NONE, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mflo_accept: got %b want %b",
                     {req_ready, md_start, md_op, rd_sel_hi, err}, {1'b1, 1'b0, OP_NONE, 1'b0, 1'b0});
        end
        vectors++;
        if (stall_cycles !== (CNT_ON ? 32'd6 : 32'd0)) begin
            miscompares++;
            $display("FAIL mflo_stall_cnt: got %0d want %0d", stall_cycles, CNT_ON ? 6 : 0);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        do_reset();
        apply(1'b1, K_DIVU, 1'b0);
        vectors++;
        if ({md_start, md_op} !== {1'b1, OP_DIVU}) begin
            miscompares++;
            $display("FAIL divu_issue: got %b want %b", {md_start, md_op}, {1'b1, OP_DIVU});
        end
        adv();
        for (int c = 1; c <= 11; c++) begin
            apply(1'b1, K_MULTU, 1'b0);
            vectors++;
            if ({req_ready, md_start} !== 2'b00) begin
                miscompares++;
                $display("FAIL multu_stall_c%0d: got %b want 00", c, {req_ready, md_start});
            end
            adv();
        end
        apply(1'b1, K_MULTU, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op} !== {1'b1, 1'b1, OP_MULTU}) begin
            miscompares++;
            $display("FAIL multu_issue: got %b want %b", {req_ready, md_start, md_op}, {1'b1, 1'b1, OP_MULTU});
        end
        vectors++;
        if (stall_cycles !== (CNT_ON ? 32'd11 : 32'd0)) begin
            miscompares++;
            $display("FAIL b2b_stall_cnt: got %0d want %0d", stall_cycles, CNT_ON ? 11 : 0);
        end
        adv();
        idle_cycles(8);
        apply(1'b0, K_NONE, 1'b0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_err: got %b want 0", err);
        end
    endtask

    task automatic test_mthi();
        do_reset();
        apply(1'b1, K_MTHI, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op} !== {1'b1, 1'b0, OP_MTHI}) begin
            miscompares++;
            $display("FAIL mthi: got %b want %b", {req_ready, md_start, md_op}, {1'b1, 1'b0, OP_MTHI});
        end
        adv();
        apply(1'b1, K_MTLO, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op} !== {1'b1, 1'b0, OP_MTLO}) begin
            miscompares++;
            $display("FAIL mtlo: got %b want %b", {req_ready, md_start, md_op}, {1'b1, 1'b0, OP_MTLO});
        end
        adv();
        apply(1'b0, K_MTHI, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op} !== {1'b1, 1'b0, OP_NONE}) begin
            miscompares++;
            $display("FAIL mthi_not_valid: got %b want %b", {req_ready, md_start, md_op}, {1'b1, 1'b0, OP_NONE});
        end
        adv();
        apply(1'b1, K_MFHI, 1'b0);
        vectors++;
        if ({req_ready, rd_sel_hi} !== 2'b11) begin
            miscompares++;
            $display("FAIL mthi_still_idle: got %b want 11", {req_ready, rd_sel_hi});
        end
        adv();
    endtask

    task automatic test_flush();
        do_reset();
        apply(1'b1, K_MULT, 1'b1);
        vectors++;
        if ({req_ready, md_start, md_op} !== {1'b1, 1'b0, OP_NONE}) begin
            miscompares++;
            $display("FAIL flush_idle: got %b want %b", {req_ready, md_start, md_op}, {1'b1, 1'b0, OP_NONE});
        end
        adv();
        apply(1'b1, K_MULT, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op, md_busy} !== {1'b1, 1'b1, OP_MULT, 1'b0}) begin
            miscompares++;
            $display("FAIL flush_then_mult: got %b want %b",
                     {req_ready, md_start, md_op, md_busy}, {1'b1, 1'b1, OP_MULT, 1'b0});
        end
        adv();
        adv();
        apply(1'b1, K_MFHI, 1'b1);
        vectors++;
        if ({req_ready, md_start, rd_sel_hi} !== 3'b100) begin
            miscompares++;
            $display("FAIL flush_wait: got %b want 100", {req_ready, md_start, rd_sel_hi});
        end
        adv();
        apply(1'b1, K_MFHI, 1'b0);
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_no_abort: got %b want 0", req_ready);
        end
        vectors++;
        if (stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL flush_stall_cnt: got %0d want 0", stall_cycles);
        end
        adv();
        idle_cycles(6);
        apply(1'b0, K_NONE, 1'b0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_err: got %b want 0", err);
        end
    endtask

    task automatic test_dead_unit();
        do_reset();
        unit_dead = 1'b1;
        apply(1'b1, K_MULT, 1'b0);
        adv();
        apply(1'b1, K_MFHI, 1'b0);
        vectors++;
        if ({req_ready, err} !== 2'b00) begin
            miscompares++;
            $display("FAIL dead_issue: got %b want 00", {req_ready, err});
        end
        adv();
        apply(1'b1, K_MFHI, 1'b0);
        vectors++;
        if ({req_ready, rd_sel_hi, err} !== 3'b111) begin
            miscompares++;
            $display("FAIL dead_err_set: got %b want 111", {req_ready, rd_sel_hi, err});
        end
        adv();
        idle_cycles(5);
        apply(1'b0, K_NONE, 1'b0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL dead_err_sticky: got %b want 1", err);
        end
        do_reset();
        apply(1'b0, K_NONE, 1'b0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL dead_err_clear: got %b want 0", err);
        end
    endtask

    task automatic test_short_busy();
        do_reset();
        mul_len = 4;
        apply(1'b1, K_MULT, 1'b0);
        adv();
        idle_cycles(7);
        apply(1'b0, K_NONE, 1'b0);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL short_busy_err: got %b want 1", err);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        apply(1'b1, K_DIV, 1'b0);
        vectors++;
        if ({md_start, md_op} !== {1'b1, OP_DIV}) begin
            miscompares++;
            $display("FAIL div_issue: got %b want %b", {md_start, md_op}, {1'b1, OP_DIV});
        end
        adv();
        for (int c = 1; c <= 2; c++) begin
            apply(1'b1, K_MFHI, 1'b0);
            adv();
        end
        rst = 1'b1;
        apply(1'b1, K_MFHI, 1'b0);
        adv();
        rst = 1'b0;
        apply(1'b1, K_MFHI, 1'b0);
        vectors++;
        if ({req_ready, md_start, md_op, rd_sel_hi, err} !== {1'b1, 1'b0, OP_NONE, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_mid_mfhi: got %b want %b",
                     {req_ready, md_start, md_op, rd_sel_hi, err}, {1'b1, 1'b0, OP_NONE, 1'b1, 1'b0});
        end
        vectors++;
        if (stall_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_stall_cnt: got %0d want 0", stall_cycles);
        end
        adv();
        idle_cycles(12);
        apply(1'b0, K_NONE, 1'b0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_err: got %b want 0", err);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mult_mflo();
        test_back_to_back();
        test_mthi();
        test_flush();
        test_dead_unit();
        test_short_busy();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
